// File: rtl/emulador_de_teclado.sv
`default_nettype none
// ============================================================================
// Module  : emulador_de_teclado
// Brief   : 4x4 matrix-keypad emulator answering the lin_matriz row scan.
//           Optional contact bounce is enabled by the EMULADOR_BOUNCE_EN macro.
// Revision: 1.0
// ============================================================================
module emulador_de_teclado #(
  parameter int          BOUNCE_CYCLES = 2000,
  parameter int          GAP_CYCLES    = 1000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  lin_matriz,
  output logic [3:0]  col_matriz,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_key,
  input  logic [15:0] cmd_hold_cycles,
  output logic        busy,
  output logic        done,
  output logic        contact
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_BOUNCE_P = 3'd1,
    S_HOLD     = 3'd2,
    S_BOUNCE_R = 3'd3,
    S_GAP      = 3'd4
  } state_t;

  localparam logic [15:0] C_GAP_LOAD = 16'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        contact_q, contact_d;
  logic        done_q, done_d;
  logic [1:0]  row_q, row_d;
  logic [1:0]  col_q, col_d;
  logic [1:0]  w_key_row, w_key_col;
  logic [15:0] w_hold_load;

`ifdef EMULADOR_BOUNCE_EN
  localparam logic [15:0] C_BOUNCE_LOAD = 16'(BOUNCE_CYCLES - 1);
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] hold_q, hold_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{LFSR_SEED, 32'(BOUNCE_CYCLES)};
`endif

  // Keypad layout: r0 "1 2 3 A", r1 "4 5 6 B", r2 "7 8 9 C", r3 "* 0 # D"
  always_comb begin
    w_key_row = 2'd0;
    w_key_col = 2'd0;
    case (cmd_key)
      4'h1: begin w_key_row = 2'd0; w_key_col = 2'd0; end
      4'h2: begin w_key_row = 2'd0; w_key_col = 2'd1; end
      4'h3: begin w_key_row = 2'd0; w_key_col = 2'd2; end
      4'hA: begin w_key_row = 2'd0; w_key_col = 2'd3; end
      4'h4: begin w_key_row = 2'd1; w_key_col = 2'd0; end
      4'h5: begin w_key_row = 2'd1; w_key_col = 2'd1; end
      4'h6: begin w_key_row = 2'd1; w_key_col = 2'd2; end
      4'hB: begin w_key_row = 2'd1; w_key_col = 2'd3; end
      4'h7: begin w_key_row = 2'd2; w_key_col = 2'd0; end
      4'h8: begin w_key_row = 2'd2; w_key_col = 2'd1; end
      4'h9: begin w_key_row = 2'd2; w_key_col = 2'd2; end
      4'hC: begin w_key_row = 2'd2; w_key_col = 2'd3; end
      4'hE: begin w_key_row = 2'd3; w_key_col = 2'd0; end
      4'h0: begin w_key_row = 2'd3; w_key_col = 2'd1; end
      4'hF: begin w_key_row = 2'd3; w_key_col = 2'd2; end
      default: begin w_key_row = 2'd3; w_key_col = 2'd3; end
    endcase
  end

  assign w_hold_load = (cmd_hold_cycles == 16'd0) ? 16'd0 : cmd_hold_cycles - 16'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    row_d   = row_q;
    col_d   = col_q;
`ifdef EMULADOR_BOUNCE_EN
    lfsr_d  = lfsr_q;
    hold_d  = hold_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          row_d = w_key_row;
          col_d = w_key_col;
`ifdef EMULADOR_BOUNCE_EN
          hold_d  = w_hold_load;
          state_d = S_BOUNCE_P;
          cnt_d   = C_BOUNCE_LOAD;
`else
          state_d = S_HOLD;
          cnt_d   = w_hold_load;
`endif
        end
      end
`ifdef EMULADOR_BOUNCE_EN
      S_BOUNCE_P: begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        if (cnt_q == 16'd0) begin
          state_d = S_HOLD;
          cnt_d   = hold_q;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_BOUNCE_R: begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        if (cnt_q == 16'd0) begin
          state_d = S_GAP;
          cnt_d   = C_GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`endif
      S_HOLD: begin
        if (cnt_q == 16'd0) begin
`ifdef EMULADOR_BOUNCE_EN
          state_d = S_BOUNCE_R;
          cnt_d   = C_BOUNCE_LOAD;
`else
          state_d = S_GAP;
          cnt_d   = C_GAP_LOAD;
`endif
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 16'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Contact is registered against the state being entered, so it is valid in that state's first cycle
    contact_d = (state_d == S_HOLD);
`ifdef EMULADOR_BOUNCE_EN
    if (state_d == S_BOUNCE_P || state_d == S_BOUNCE_R) contact_d = lfsr_d[0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      contact_q <= 1'b0;
      done_q    <= 1'b0;
      row_q     <= 2'd0;
      col_q     <= 2'd0;
`ifdef EMULADOR_BOUNCE_EN
      lfsr_q    <= LFSR_SEED;
      hold_q    <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      contact_q <= contact_d;
      done_q    <= done_d;
      row_q     <= row_d;
      col_q     <= col_d;
`ifdef EMULADOR_BOUNCE_EN
      lfsr_q    <= lfsr_d;
      hold_q    <= hold_d;
`endif
    end
  end

  always_comb begin
    col_matriz = 4'hF;
    if (contact_q && !lin_matriz[row_q]) col_matriz[col_q] = 1'b0;
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign contact   = contact_q;

endmodule
`default_nettype wire

// File: tb/tb_emulador_de_teclado.sv
`default_nettype none
// ============================================================================
// Module  : tb_emulador_de_teclado
// Brief   : Randomised self-checking bench for emulador_de_teclado against a
//           phase-timeline keypad model.
// Revision: 1.0
// ============================================================================
module tb_emulador_de_teclado;

  localparam int          B    = 8;
  localparam int          G    = 4;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef EMULADOR_BOUNCE_EN
  localparam bit BOUNCE_EN = 1'b1;
`else
  localparam bit BOUNCE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  lin_matriz = 4'hF;
  logic [3:0]  col_matriz;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_key = 4'h0;
  logic [15:0] cmd_hold_cycles = 16'd0;
  logic        busy, done, contact;

  int n_checks = 0;
  int n_errors = 0;

  emulador_de_teclado #(.BOUNCE_CYCLES(B), .GAP_CYCLES(G), .LFSR_SEED(SEED)) u_dut (
    .clk(clk), .rst(rst), .lin_matriz(lin_matriz), .col_matriz(col_matriz),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key),
    .cmd_hold_cycles(cmd_hold_cycles), .busy(busy), .done(done), .contact(contact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: key position table built from the printed layout
  int key_r[16];
  int key_c[16];
  bit m_act;
  int m_t, m_total, m_h, m_r, m_c;
  logic [15:0] m_lfsr;
  bit exp_contact, exp_done;

  function automatic int char_code(input byte ch);
    if (ch >= "0" && ch <= "9") return int'(ch - "0");
    if (ch >= "A" && ch <= "D") return int'(ch - "A") + 10;
    if (ch == "*") return 14;
    return 15;
  endfunction

  task automatic build_layout();
    string lay;
    lay = "123A456B789C*0#D";
    for (int i = 0; i < 16; i++) begin
      key_r[char_code(lay[i])] = i / 4;
      key_c[char_code(lay[i])] = i % 4;
    end
  endtask

  function automatic bit bounce_bit();
    bit b;
    b = m_lfsr[0];
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    return b;
  endfunction

  task automatic model_edge(input bit r, input bit v, input logic [3:0] key, input logic [15:0] hold);
    exp_done = 1'b0;
    exp_contact = 1'b0;
    if (r) begin
      m_act = 1'b0;
      m_lfsr = SEED;
      m_r = 0;
      m_c = 0;
      return;
    end
    if (m_act) begin
      m_t++;
      if (m_t == m_total) begin
        m_act = 1'b0;
        exp_done = 1'b1;
      end
    end else if (v) begin
      m_act = 1'b1;
      m_t = 1;
      m_h = (hold == 16'd0) ? 1 : int'(hold);
      m_r = key_r[key];
      m_c = key_c[key];
      m_total = BOUNCE_EN ? (2 * B + m_h + G + 1) : (m_h + G + 1);
    end
    if (m_act) begin
      if (BOUNCE_EN) begin
        if (m_t <= B)                  exp_contact = bounce_bit();
        else if (m_t <= B + m_h)       exp_contact = 1'b1;
        else if (m_t <= 2 * B + m_h)   exp_contact = bounce_bit();
      end else begin
        exp_contact = (m_t <= m_h);
      end
    end
  endtask

  task automatic check_outputs();
    logic [3:0] ec;
    ec = 4'hF;
    if (exp_contact && !lin_matriz[m_r]) ec[m_c] = 1'b0;
    chk("col_matriz", 32'(col_matriz), 32'(ec));
    chk("cmd_ready", 32'(cmd_ready), 32'(!m_act));
    chk("busy", 32'(busy), 32'(m_act));
    chk("done", 32'(done), 32'(exp_done));
    chk("contact", 32'(contact), 32'(exp_contact));
  endtask

  // One clock cycle: inputs presented before the edge, outputs checked after it
  task automatic step(input logic [3:0] lin, input bit v, input logic [3:0] key,
                      input logic [15:0] hold, input bit r);
    rst = r;
    cmd_valid = v;
    cmd_key = key;
    cmd_hold_cycles = hold;
    @(posedge clk);
    model_edge(r, v, key, hold);
    #1 lin_matriz = lin;
    #1 check_outputs();
  endtask

  task automatic press(input logic [3:0] key, input logic [15:0] hold, input logic [3:0] lin, input int tail);
    step(lin, 1'b1, key, hold, 1'b0);
    while (m_act) step(lin, 1'b0, 4'h0, 16'd0, 1'b0);
    for (int i = 0; i < tail; i++) step(lin, 1'b0, 4'h0, 16'd0, 1'b0);
  endtask

  initial begin
    logic [3:0] pat[3];
    build_layout();
    m_act = 1'b0;
    m_lfsr = SEED;
    m_r = 0;
    m_c = 0;

    // Reset, then row sweep while idle
    for (int i = 0; i < 3; i++) step(4'hF, 1'b0, 4'h0, 16'd0, 1'b1);
    for (int i = 0; i < 16; i++) step(4'(i), 1'b0, 4'h0, 16'd0, 1'b0);

    // Key 5 with row patterns cycled through the press
    pat[0] = 4'b1101; pat[1] = 4'b1110; pat[2] = 4'b0000;
    step(pat[0], 1'b1, 4'h5, 16'd20, 1'b0);
    for (int i = 0; m_act && i < 200; i++) step(pat[i % 3], 1'b0, 4'h0, 16'd0, 1'b0);

    press(4'hF, 16'd10, 4'b0111, 2);

    // Key 1, a competing request while busy, then reset mid-hold
    step(4'b1110, 1'b1, 4'h1, 16'd20, 1'b0);
    for (int i = 0; i < (BOUNCE_EN ? B + 5 : 5); i++) step(4'b1110, 1'b1, 4'h9, 16'd3, 1'b0);
    step(4'b1110, 1'b0, 4'h0, 16'd0, 1'b1);
    for (int i = 0; i < 40; i++) step(4'b1110, 1'b0, 4'h0, 16'd0, 1'b0);

    press(4'h0, 16'd12, 4'b0111, 1);
    press(4'h2, 16'd5, 4'b1110, 1);
    press(4'hD, 16'd0, 4'b0111, 0);

    // Random presses with random row scans, busy-time noise and rare resets
    for (int p = 0; p < 40; p++) begin
      logic [3:0]  k;
      logic [15:0] h;
      k = 4'($urandom_range(0, 15));
      h = 16'($urandom_range(0, 15));
      step(4'($urandom), 1'b1, k, h, 1'b0);
      for (int i = 0; m_act && i < 200; i++) begin
        step(4'($urandom), 1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom_range(0, 9)),
             ($urandom_range(0, 299) == 0));
      end
      for (int i = 0; i < int'($urandom_range(0, 3)); i++)
        step(4'($urandom), 1'b0, 4'h0, 16'd0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
